// File: rtl/asi_pkg.sv
// Shared definitions for the ASI Manchester slave-frame encoder and decoder.
package asi_pkg;

  // clk_in cycles per Manchester half-bit (3 us at 12 MHz)
  localparam int HALF_BIT = 36;
  // Bits per slave frame: start, D3..D0, parity, end
  localparam int NBITS    = 7;
  localparam int FRAME_W  = 7;

  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_END_BIT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Assemble a slave frame MSB-first: start, nibble, even parity, end
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] nibble);
    return {FRAME_START_BIT, nibble, ^nibble, FRAME_END_BIT};
  endfunction

endpackage

// File: rtl/man_halfbit_timer.sv
// Half-bit timer: counts HALF_BIT cycles per half-bit while enabled, raises a
// wrap strobe on the last cycle of each half and tracks which half is active.
module man_halfbit_timer #(
  parameter int HALF_BIT = 36
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  output logic wrap,
  output logic half
);

  logic [5:0] cnt;

  // Strobe on the final cycle of the current half-bit
  assign wrap = en && (cnt == 6'(HALF_BIT - 1));

  // Count within a half-bit and flip the half flag at every wrap
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      cnt  <= '0;
      half <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      half <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      half <= ~half;
    end else begin
      cnt <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/man_encoding.sv
// Manchester encoder for ASI slave response frames. A bit 0 is sent
// high-then-low, a bit 1 low-then-high; the line idles high.
module man_encoding #(
  parameter int HALF_BIT = asi_pkg::HALF_BIT,
  parameter int NBITS    = asi_pkg::NBITS
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data,
  output logic       manchester,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  import asi_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(NBITS - 1);

  state_t             state;
  logic [FRAME_W-1:0] shift_reg;
  logic [2:0]         bit_cnt;
  logic               wrap;
  logic               half;

  man_halfbit_timer #(
    .HALF_BIT(HALF_BIT)
  ) u_timer (
    .clk_in(clk_in),
    .rst   (rst),
    .en    (state == SEND),
    .wrap  (wrap),
    .half  (half)
  );

  // Frame FSM: latch the frame, drive each half-bit, pulse done, return idle
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      manchester <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_reg  <= build_frame(data);
            bit_cnt    <= '0;
            // First half of the start bit goes out on the very next cycle
            manchester <= ~FRAME_START_BIT;
            ready      <= 1'b0;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end

        SEND: begin
          if (wrap) begin
            if (!half) begin
              // Second half carries the bit value itself
              manchester <= shift_reg[FRAME_W-1];
            end else begin
              shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                manchester <= 1'b1;
                busy       <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end else begin
                // First half of the next bit is its complement
                manchester <= ~shift_reg[FRAME_W-2];
              end
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          ready     <= 1'b1;
          shift_reg <= '0;
          bit_cnt   <= '0;
          state     <= IDLE;
        end

        default: begin
          state      <= IDLE;
          manchester <= 1'b1;
          ready      <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/man_encoding.md
MAN_ENCODING -- requirements
Module: man_encoding

Interface
REQ-001 Parameter HALF_BIT, default 36, clk_in cycles per Manchester half-bit (3 us at 12 MHz).
REQ-002 Parameter NBITS, default 7, bits per slave frame: start, D3..D0, parity, end.
REQ-003 clk_in  input  1  system clock, 12 MHz; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to transmit one frame; honoured only when ready=1.
REQ-006 data  input  4  response nibble D3..D0; sampled in the cycle start is accepted.
REQ-007 manchester  output  1  encoded serial line, registered; idle level 1.
REQ-008 ready  output  1  high in IDLE; a new start is accepted only while ready=1.
REQ-009 busy  output  1  high from the first driven half-bit through the last half-bit.
REQ-010 done  output  1  one-cycle pulse after the last half-bit completes.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-012 In IDLE with start=1, the block SHALL latch frame {0, D3, D2, D1, D0, P, 1} MSB-first into a 7-bit shift register and go to SEND next cycle, with P = D3^D2^D1^D0 (even parity).
REQ-013 Bit 0 SHALL be encoded high-then-low, bit 1 low-then-high; each half SHALL last exactly HALF_BIT cycles.
REQ-014 manchester SHALL show the first half of the start bit in the cycle after start is accepted (1-cycle latency).
REQ-015 A 6-bit half-bit counter SHALL count 0..HALF_BIT-1 and wrap; a half flag SHALL toggle on each wrap; the shift register SHALL advance and a 3-bit bit counter SHALL increment when half=1 wraps.
REQ-016 After 2*NBITS half-bits (504 cycles at defaults), the FSM SHALL enter DONE for one cycle with done=1, busy=0, manchester=1, then return to IDLE.
REQ-017 busy SHALL be high for exactly 2*NBITS*HALF_BIT cycles per frame.
REQ-018 start asserted while busy=1 or in DONE SHALL be ignored; no queuing.
REQ-019 Changes on data outside the accept cycle SHALL NOT affect the frame in flight.
REQ-020 start asserted in the same cycle the FSM re-enters IDLE SHALL be accepted; back-to-back frames are separated by at least one idle-high cycle (DONE).
REQ-021 ready SHALL be 1 only in IDLE, 0 in SEND and DONE.

Reset
REQ-022 rst=0 at a clock edge SHALL force IDLE, manchester=1, ready=1, busy=0, done=0, counters and shift register 0, in the same edge.
REQ-023 rst=0 mid-frame SHALL abort the frame with no done pulse; line returns to 1 on the next edge.
REQ-024 start during rst=0 SHALL be ignored.

Structure
REQ-025 A shared package asi_pkg SHALL hold HALF_BIT, NBITS, the state encoding, and the frame start/end bit constants for use by man_encoding and man_decoding.
REQ-026 The block SHALL contain one sub-module, man_halfbit_timer, generating the half-bit wrap strobe and half flag.
REQ-027 No other sub-modules; no combinational path from start/data to manchester.

Verification
REQ-028 data=4'b1010, start pulse -> frame 0,1,0,1,0,0,1; manchester = H L, L H, H L, L H, H L, H L, L H, 36 cycles per half, done pulse at cycle 505.
REQ-029 data=4'b0111 -> P=1; frame 0,0,1,1,1,1,1; decoding by man_decoding sampling every 72 cycles returns the same 7 bits.
REQ-030 start re-pulsed at cycles 100 and 300 of a frame -> ignored; busy stays high exactly 504 cycles; one done pulse.
REQ-031 rst=0 at cycle 200 of a frame -> manchester=1, busy=0, ready=1 next edge; no done; a fresh start then yields a full correct frame.
REQ-032 start held high continuously with data=4'b0000 -> consecutive frames, each 504 busy cycles separated by exactly one DONE cycle with manchester=1.
